trap_monitor: RTL and testbench
===============================

TRAP_MONITOR -- requirements
Module: trap_monitor

Interface
REQ-001 SHALL have parameter NR_COMMIT, default 2: number of commit channels, legal range 1..4.
REQ-002 SHALL have parameter XLEN, default 64: width of pc and a0.
REQ-003 SHALL have parameter TIMEOUT, default 5000: cycles without any commit before a hang is declared; 0 disables the check.
REQ-004 SHALL have parameter DRAIN_CYC, default 4: cycles between exit detection and halt.
REQ-005 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port commit_valid, input, NR_COMMIT: per-channel commit strobe; channel 0 is oldest in program order.
REQ-008 SHALL have port commit_pc, input, NR_COMMIT*XLEN: channel i occupies bits [i*XLEN +: XLEN].
REQ-009 SHALL have port commit_inst, input, NR_COMMIT*32: channel i occupies bits [i*32 +: 32].
REQ-010 SHALL have port commit_exit, input, NR_COMMIT: channel i is the trap (ebreak) instruction; ignored unless commit_valid[i] is 1.
REQ-011 SHALL have port a0, input, XLEN: architectural a0 as seen by the exit instruction.
REQ-012 SHALL have port halted, output, 1: state is HALT.
REQ-013 SHALL have port result, output, 2: 00 running, 01 good trap, 10 bad trap, 11 timeout.
REQ-014 SHALL have ports halt_pc (XLEN), halt_inst (32) and exit_code (XLEN), all outputs: values latched at exit.
REQ-015 SHALL have ports commit_cnt and cycle_cnt, output, 64 each: performance counters.

Function
REQ-016 SHALL implement states RUN, DRAIN and HALT, entering RUN on reset.
REQ-017 In RUN, e = the lowest index i with commit_valid[i] and commit_exit[i]; exit channels above e SHALL be ignored.
REQ-018 In the exit cycle, channels with index above e SHALL NOT count; channels 0..e SHALL count.
REQ-019 On exit in RUN, the block SHALL, at the next edge: latch halt_pc, halt_inst and exit_code from channel e and a0; load the drain counter with DRAIN_CYC; go to DRAIN.
REQ-020 In DRAIN, the drain counter SHALL decrement each cycle; when it is 0, or DRAIN_CYC = 0, the block SHALL go to HALT at the next edge.
REQ-021 On the DRAIN to HALT edge, result SHALL become 01 if exit_code = 0, else 10.
REQ-022 In RUN, the idle counter SHALL reset to 0 on any cycle where any commit_valid bit is 1, else increment.
REQ-023 When TIMEOUT ≠ 0 and the idle counter reaches TIMEOUT-1 with no commit, the block SHALL go directly to HALT with result 11 and halt_pc/halt_inst/exit_code unchanged.
REQ-024 An exit and a commit in the same cycle as the timeout threshold SHALL take priority over the timeout.
REQ-025 cycle_cnt SHALL increment every cycle in RUN and DRAIN and hold in HALT.
REQ-026 commit_cnt SHALL add popcount of counted valid channels in RUN only; commits in DRAIN or HALT SHALL NOT count.
REQ-027 commit_cnt and cycle_cnt SHALL saturate at 2^64-1 (no wrap).
REQ-028 HALT SHALL be terminal; only reset leaves it.
REQ-029 Simulation only: on entry to HALT the block SHALL print exactly once either "hit good trap", "hit bad trap" or "hit timeout", with halt_pc, halt_inst and commit_cnt, then call $finish; synthesis SHALL exclude this code.
REQ-030 commit_exit without the matching commit_valid SHALL have no effect.

Reset
REQ-031 While reset is 1 at a clock edge, the block SHALL set: state RUN; halted 0; result 00; halt_pc, halt_inst, exit_code, commit_cnt, cycle_cnt 0; idle and drain counters 0.
REQ-032 Reset asserted in DRAIN or HALT SHALL abort the pending halt and suppress the print.

Verification
REQ-033 Commits on channel 0 for 10 cycles, then exit on channel 0 with pc=0x80000010, a0=0 -> DRAIN 4 cycles; then halted=1, result=01, halt_pc=0x80000010, commit_cnt=11.
REQ-034 Same cycle: valid=11, exit=11, a0=3 -> channel 0 latched; commit_cnt +1; result=10, exit_code=3.
REQ-035 Exit in DRAIN cycle 2 with further commits -> commit_cnt unchanged and halt_pc unchanged.
REQ-036 TIMEOUT=16, no commits after reset -> HALT on cycle 16, result=11, halt_pc=0.
REQ-037 Commit at idle count TIMEOUT-1 -> no timeout; idle counter = 0.
REQ-038 Reset pulse in DRAIN -> all outputs 0, state RUN, no print.

Source files
------------

// File: rtl/trap_monitor.sv
// trap_monitor: watches the commit stream for the exit (ebreak) instruction or a
// hang, drains for a fixed number of cycles, then halts with a verdict.
module trap_monitor #(
  parameter int NR_COMMIT  = 2,
  parameter int XLEN       = 64,
  parameter int TIMEOUT    = 5000,
  parameter int DRAIN_CYC  = 4,
  parameter bit SIM_FINISH = 1'b1   // end the simulation once halted
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NR_COMMIT-1:0]    commit_valid,
  input  logic [NR_COMMIT*XLEN-1:0] commit_pc,
  input  logic [NR_COMMIT*32-1:0] commit_inst,
  input  logic [NR_COMMIT-1:0]    commit_exit,
  input  logic [XLEN-1:0]         a0,
  output logic                    halted,
  output logic [1:0]              result,
  output logic [XLEN-1:0]         halt_pc,
  output logic [31:0]             halt_inst,
  output logic [XLEN-1:0]         exit_code,
  output logic [63:0]             commit_cnt,
  output logic [63:0]             cycle_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT - 1);
  localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYC);

  state_t            state, state_nxt;
  logic [31:0]       idle_cnt;
  logic [31:0]       drain_cnt;
  logic              exit_any;
  logic              any_valid;
  logic              timeout_hit;
  logic              drain_done;
  logic [XLEN-1:0]   exit_pc;
  logic [31:0]       exit_inst;
  logic [63:0]       pop;
  logic [64:0]       commit_sum;

  // Oldest exiting channel wins; only channels up to and including it are counted.
  always_comb begin
    exit_any  = 1'b0;
    exit_pc   = '0;
    exit_inst = '0;
    pop       = '0;
    for (int unsigned i = 0; i < NR_COMMIT; i++) begin
      pop = pop + 64'(commit_valid[i] & ~exit_any);
      if (!exit_any && commit_valid[i] && commit_exit[i]) begin
        exit_any  = 1'b1;
        exit_pc   = commit_pc[i*XLEN +: XLEN];
        exit_inst = commit_inst[i*32 +: 32];
      end
    end
  end

  assign any_valid   = |commit_valid;
  assign commit_sum  = {1'b0, commit_cnt} + {1'b0, pop};
  assign timeout_hit = (TIMEOUT != 0) && !any_valid && (idle_cnt == IDLE_LIMIT);
  assign drain_done  = (drain_cnt == '0) || (DRAIN_CYC == 0);
  assign halted      = (state == HALT);

  // Next-state selection; an exit always outranks the hang detector.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (exit_any)         state_nxt = DRAIN;
        else if (timeout_hit) state_nxt = HALT;
      end
      DRAIN: begin
        if (drain_done) state_nxt = HALT;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Counters, drain timer and exit snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      result     <= 2'b00;
      halt_pc    <= '0;
      halt_inst  <= '0;
      exit_code  <= '0;
      commit_cnt <= '0;
      cycle_cnt  <= '0;
      idle_cnt   <= '0;
      drain_cnt  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          cycle_cnt  <= (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 64'd1;
          commit_cnt <= commit_sum[64] ? '1 : commit_sum[63:0];
          idle_cnt   <= any_valid ? '0 : idle_cnt + 32'd1;
          if (exit_any) begin
            halt_pc   <= exit_pc;
            halt_inst <= exit_inst;
            exit_code <= a0;
            drain_cnt <= DRAIN_LOAD;
          end else if (timeout_hit) begin
            result <= 2'b11;
          end
        end
        DRAIN: begin
          cycle_cnt <= (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 64'd1;
          if (drain_done) result <= (exit_code == '0) ? 2'b01 : 2'b10;
          else            drain_cnt <= drain_cnt - 32'd1;
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Announce the verdict once, on the edge that enters HALT.
  always_ff @(posedge clock) begin
    if (!reset && state != HALT && state_nxt == HALT) begin
      if (state == RUN)
        $display("hit timeout: pc=%0h inst=%0h commits=%0d", halt_pc, halt_inst, commit_cnt);
      else if (exit_code == '0)
        $display("hit good trap: pc=%0h inst=%0h commits=%0d", halt_pc, halt_inst, commit_cnt);
      else
        $display("hit bad trap: pc=%0h inst=%0h commits=%0d", halt_pc, halt_inst, commit_cnt);
      if (SIM_FINISH) $finish;
    end
  end
`endif

endmodule

// File: tb/tb_trap_monitor.sv
// Bench for trap_monitor: vector table, directed corner sequences, and random
// episodes checked against a cycle-indexed reference model.
module tb_trap_monitor;
  localparam int NRC = 2;
  localparam int XL  = 64;
  localparam int TO  = 16;
  localparam int DC  = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NRC-1:0]  cv = '0;
  logic [NRC-1:0]  ce = '0;
  logic [XL-1:0]   pcs [NRC];
  logic [31:0]     insts [NRC];
  logic [XL-1:0]   a0 = '0;
  logic [NRC*XL-1:0] cpc;
  logic [NRC*32-1:0] cinst;
  logic            halted;
  logic [1:0]      result;
  logic [XL-1:0]   halt_pc, exit_code;
  logic [31:0]     halt_inst;
  logic [63:0]     commit_cnt, cycle_cnt;

  assign cpc   = {pcs[1], pcs[0]};
  assign cinst = {insts[1], insts[0]};

  trap_monitor #(
    .NR_COMMIT(NRC), .XLEN(XL), .TIMEOUT(TO), .DRAIN_CYC(DC), .SIM_FINISH(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .commit_valid(cv), .commit_pc(cpc),
    .commit_inst(cinst), .commit_exit(ce), .a0(a0), .halted(halted),
    .result(result), .halt_pc(halt_pc), .halt_inst(halt_inst),
    .exit_code(exit_code), .commit_cnt(commit_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; cv = '0; ce = '0; a0 = '0;
    tick;
    reset = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic h, input logic [1:0] r,
                         input logic [63:0] pc, input logic [31:0] inst,
                         input logic [63:0] code, input logic [63:0] cc,
                         input logic [63:0] cy);
    chk({tag, ".halted"}, 64'(halted), 64'(h));
    chk({tag, ".result"}, 64'(result), 64'(r));
    chk({tag, ".halt_pc"}, halt_pc, pc);
    chk({tag, ".halt_inst"}, 64'(halt_inst), 64'(inst));
    chk({tag, ".exit_code"}, exit_code, code);
    chk({tag, ".commit_cnt"}, commit_cnt, cc);
    chk({tag, ".cycle_cnt"}, cycle_cnt, cy);
  endtask

  // Reference model: cycle n is the n-th edge after reset.  An exit in cycle
  // n_e halts on the edge of cycle n_e+DC+1; a hang halts once TO consecutive
  // commit-free cycles have been seen.
  logic        m_halt;
  logic [1:0]  m_res;
  logic [63:0] m_pc, m_code, m_cc, m_cy;
  logic [31:0] m_inst;
  int          m_n, m_exit_n, m_quiet;

  task automatic model_reset;
    m_halt = 1'b0; m_res = 2'b00; m_pc = '0; m_inst = '0; m_code = '0;
    m_cc = '0; m_cy = '0; m_n = 0; m_exit_n = -1; m_quiet = 0;
  endtask

  task automatic model_step;
    int e;
    int lim;
    if (m_halt) return;
    m_cy++;
    if (m_exit_n >= 0) begin
      if (m_n == m_exit_n + DC + 1) begin
        m_halt = 1'b1;
        m_res  = (m_code == 0) ? 2'b01 : 2'b10;
      end
    end else begin
      e = -1;
      for (int i = 0; i < NRC; i++)
        if (e < 0 && cv[i] && ce[i]) e = i;
      lim = (e < 0) ? NRC - 1 : e;
      for (int i = 0; i <= lim; i++)
        if (cv[i]) m_cc++;
      if (e >= 0) begin
        m_pc = pcs[e]; m_inst = insts[e]; m_code = a0; m_exit_n = m_n;
      end
      m_quiet = (cv != 0) ? 0 : m_quiet + 1;
      if (e < 0 && m_quiet == TO) begin
        m_halt = 1'b1; m_res = 2'b11;
      end
    end
    m_n++;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  x;
    logic [63:0] a;
    logic [63:0] cc;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] code;
    logic [1:0]  res;
  } vec_t;

  localparam logic [31:0] I0 = 32'h0010_0073;
  localparam logic [31:0] I1 = 32'h0020_0073;

  vec_t vt [9];
  int   lat;

  initial begin
    pcs[0] = 64'h1000; pcs[1] = 64'h2000; insts[0] = I0; insts[1] = I1;
    vt[0] = '{2'b01, 2'b00, 64'd0, 64'd1, 64'h0,    32'h0, 64'd0, 2'b00};
    vt[1] = '{2'b11, 2'b00, 64'd0, 64'd2, 64'h0,    32'h0, 64'd0, 2'b00};
    vt[2] = '{2'b01, 2'b01, 64'd0, 64'd1, 64'h1000, I0,    64'd0, 2'b01};
    vt[3] = '{2'b11, 2'b11, 64'd3, 64'd1, 64'h1000, I0,    64'd3, 2'b10};
    vt[4] = '{2'b11, 2'b10, 64'd5, 64'd2, 64'h2000, I1,    64'd5, 2'b10};
    vt[5] = '{2'b00, 2'b11, 64'd7, 64'd0, 64'h0,    32'h0, 64'd0, 2'b00};
    vt[6] = '{2'b10, 2'b01, 64'd1, 64'd1, 64'h0,    32'h0, 64'd0, 2'b00};
    vt[7] = '{2'b10, 2'b10, 64'd0, 64'd1, 64'h2000, I1,    64'd0, 2'b01};
    vt[8] = '{2'b01, 2'b10, 64'd9, 64'd1, 64'h0,    32'h0, 64'd0, 2'b00};

    do_reset;
    chk_all("reset", 1'b0, 2'b00, 64'h0, 32'h0, 64'h0, 64'h0, 64'h0);

    // One commit cycle, then DC+1 quiet cycles: long enough to finish any drain.
    foreach (vt[k]) begin
      do_reset;
      cv = vt[k].v; ce = vt[k].x; a0 = vt[k].a;
      tick;
      cv = '0; ce = '0; a0 = '0;
      for (int j = 0; j < DC + 1; j++) tick;
      chk_all($sformatf("vec%0d", k), vt[k].res != 2'b00, vt[k].res, vt[k].pc,
              vt[k].inst, vt[k].code, vt[k].cc, 64'd6);
    end

    // Ten commits then a good exit on channel 0.
    do_reset;
    for (int k = 0; k < 10; k++) begin
      cv = 2'b01; pcs[0] = 64'h8000_0000 + 64'(4 * k); tick;
    end
    pcs[0] = 64'h8000_0010; cv = 2'b01; ce = 2'b01; a0 = '0;
    tick;
    cv = '0; ce = '0;
    lat = 0;
    while (!halted && lat < 20) begin tick; lat++; end
    chk("good.latency", 64'(lat), 64'(DC + 1));
    chk_all("good", 1'b1, 2'b01, 64'h8000_0010, I0, 64'h0, 64'd11, 64'd16);

    // Commits and a second exit during drain are ignored.
    do_reset;
    pcs[0] = 64'h100; pcs[1] = 64'h104; cv = 2'b11; ce = 2'b01; a0 = 64'd9;
    tick;
    cv = '0; ce = '0; a0 = '0;
    tick;
    pcs[0] = 64'h200; pcs[1] = 64'h204; cv = 2'b11; ce = 2'b11;
    tick;
    cv = '0; ce = '0;
    for (int j = 0; j < 3; j++) tick;
    chk_all("drainx", 1'b1, 2'b10, 64'h100, I0, 64'd9, 64'd1, 64'd6);

    // Timeout exactly on cycle TO, then HALT is terminal.
    do_reset;
    for (int j = 0; j < TO - 1; j++) tick;
    chk("to.early", 64'(halted), 64'd0);
    tick;
    chk_all("to", 1'b1, 2'b11, 64'h0, 32'h0, 64'h0, 64'h0, 64'(TO));
    pcs[0] = 64'h500; cv = 2'b01; ce = 2'b01; a0 = 64'd1;
    for (int j = 0; j < 3; j++) tick;
    cv = '0; ce = '0; a0 = '0;
    chk_all("term", 1'b1, 2'b11, 64'h0, 32'h0, 64'h0, 64'h0, 64'(TO));

    // A commit at the threshold cycle clears the idle count.
    do_reset;
    for (int j = 0; j < TO - 1; j++) tick;
    cv = 2'b01; tick; cv = '0;
    chk("thr.commit", 64'(halted), 64'd0);
    for (int j = 0; j < TO - 1; j++) tick;
    chk("thr.again", 64'(halted), 64'd0);
    tick;
    chk("thr.to", 64'(result), 64'd3);

    // An exit at the threshold cycle beats the timeout.
    do_reset;
    for (int j = 0; j < TO - 1; j++) tick;
    pcs[0] = 64'h300; cv = 2'b01; ce = 2'b01;
    tick;
    cv = '0; ce = '0;
    chk("thrx.pc", halt_pc, 64'h300);
    chk("thrx.halted", 64'(halted), 64'd0);
    for (int j = 0; j < DC + 1; j++) tick;
    chk("thrx.result", 64'(result), 64'd1);

    // Reset during drain aborts the pending halt.
    do_reset;
    pcs[0] = 64'h400; cv = 2'b01; ce = 2'b01; a0 = 64'd4;
    tick;
    cv = '0; ce = '0; a0 = '0;
    tick; tick;
    reset = 1'b1; tick; reset = 1'b0;
    chk_all("rstdrain", 1'b0, 2'b00, 64'h0, 32'h0, 64'h0, 64'h0, 64'h0);
    for (int j = 0; j < DC + 2; j++) tick;
    chk("rstdrain.run", 64'(halted), 64'd0);

    // Random episodes against the reference model.
    for (int ep = 0; ep < 25; ep++) begin
      bit quiet;
      quiet = ($urandom_range(0, 3) == 0);
      do_reset;
      model_reset;
      for (int c = 0; c < 80; c++) begin
        for (int i = 0; i < NRC; i++) begin
          cv[i] = quiet ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1);
          ce[i] = ($urandom_range(0, 19) == 0);
          pcs[i] = {$urandom, $urandom};
          insts[i] = $urandom;
        end
        a0 = ($urandom_range(0, 1) == 1) ? 64'h0 : {32'h0, $urandom};
        model_step;
        tick;
        chk_all($sformatf("rnd%0d.%0d", ep, c), m_halt, m_res, m_pc, m_inst,
                m_code, m_cc, m_cy);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
